// File: rtl/ula_pkg.sv
// Shared opcode map and FSM state type for the sequential ALU.
package ula_pkg;

   localparam logic [3:0] OP_ADD = 4'b0011;
   localparam logic [3:0] OP_OR  = 4'b0100;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_NOT = 4'b0110;
   localparam logic [3:0] OP_SUB = 4'b0111;
   localparam logic [3:0] OP_SHR = 4'b1000;
   localparam logic [3:0] OP_SHL = 4'b1001;
   localparam logic [3:0] OP_MUL = 4'b1010;

   typedef enum logic {IDLE, BUSY} state_t;

endpackage

// File: rtl/ula_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per clock, done strobes on the last bit.
module ula_mul_iter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 i_CLK,
   input  logic                 i_RST_N,
   input  logic                 i_START,
   input  logic [WIDTH-1:0]     i_A,
   input  logic [WIDTH-1:0]     i_B,
   output logic                 o_DONE,
   output logic [2*WIDTH-1:0]   o_PRODUCT
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   logic [WIDTH-1:0]   mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_d;
   logic [2*WIDTH-1:0] partial;
   logic [CntW-1:0]    cnt_q;
   logic               run_q;

   always_comb begin
      partial = '0;
      if (mplier_q[cnt_q]) begin
         partial = {{WIDTH{1'b0}}, mcand_q} << cnt_q;
      end
      acc_d = acc_q + partial;
   end

   // Product includes the final iteration so the top can load it on the same edge.
   assign o_DONE    = run_q && (cnt_q == LastCnt);
   assign o_PRODUCT = acc_d;

   always_ff @(posedge i_CLK) begin
      if (!i_RST_N) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b0;
      end else if (i_START) begin
         mcand_q  <= i_A;
         mplier_q <= i_B;
         acc_q    <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b1;
      end else if (run_q) begin
         acc_q <= acc_d;
         if (o_DONE) begin
            run_q <= 1'b0;
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CntW'(1);
         end
      end
   end

endmodule

// File: rtl/ula_seq.sv
// Sequential Neander-compatible ALU: single-cycle ops complete on accept, MUL runs iteratively.
module ula_seq
   import ula_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             i_CLK,
   input  logic             i_RST_N,
   input  logic             i_VALID,
   output logic             o_READY,
   input  logic [3:0]       i_SEL,
   input  logic [WIDTH-1:0] i_A,
   input  logic [WIDTH-1:0] i_B,
   output logic             o_VALID,
   output logic [WIDTH-1:0] o_OUT,
   output logic             o_ZERO,
   output logic             o_NEG,
   output logic             o_CARRY,
   output logic             o_OVF
);

   state_t             state_q;
   state_t             state_d;
   logic               accept;
   logic               mul_start;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_product;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     diff;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_carry;
   logic               alu_ovf;
   logic               load;
   logic [WIDTH-1:0]   res_d;
   logic               carry_d;
   logic               ovf_d;

   assign o_READY   = (state_q == IDLE) && i_RST_N;
   assign accept    = i_VALID && o_READY;
   assign mul_start = accept && (i_SEL == OP_MUL);

   ula_mul_iter #(
      .WIDTH (WIDTH)
   ) u_mul (
      .i_CLK     (i_CLK),
      .i_RST_N   (i_RST_N),
      .i_START   (mul_start),
      .i_A       (i_A),
      .i_B       (i_B),
      .o_DONE    (mul_done),
      .o_PRODUCT (mul_product)
   );

   always_comb begin
      sum       = {1'b0, i_A} + {1'b0, i_B};
      diff      = {1'b0, i_A} - {1'b0, i_B};
      alu_res   = i_B;
      alu_carry = 1'b0;
      alu_ovf   = 1'b0;
      case (i_SEL)
         OP_ADD: begin
            alu_res   = sum[WIDTH-1:0];
            alu_carry = sum[WIDTH];
            alu_ovf   = (i_A[WIDTH-1] == i_B[WIDTH-1]) && (sum[WIDTH-1] != i_A[WIDTH-1]);
         end
         OP_OR:  alu_res = i_A | i_B;
         OP_AND: alu_res = i_A & i_B;
         OP_NOT: alu_res = ~i_A;
         OP_SUB: begin
            alu_res   = diff[WIDTH-1:0];
            alu_carry = diff[WIDTH];
            alu_ovf   = (i_A[WIDTH-1] != i_B[WIDTH-1]) && (diff[WIDTH-1] != i_A[WIDTH-1]);
         end
         OP_SHR: begin
            alu_res   = {1'b0, i_A[WIDTH-1:1]};
            alu_carry = i_A[0];
         end
         OP_SHL: begin
            alu_res   = {i_A[WIDTH-2:0], 1'b0};
            alu_carry = i_A[WIDTH-1];
         end
         default: alu_res = i_B;
      endcase
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      res_d   = alu_res;
      carry_d = alu_carry;
      ovf_d   = alu_ovf;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (i_SEL == OP_MUL) begin
                  state_d = BUSY;
               end else begin
                  load = 1'b1;
               end
            end
         end
         BUSY: begin
            if (mul_done) begin
               state_d = IDLE;
               load    = 1'b1;
               res_d   = mul_product[WIDTH-1:0];
               carry_d = |mul_product[2*WIDTH-1:WIDTH];
               ovf_d   = |mul_product[2*WIDTH-1:WIDTH];
            end
         end
      endcase
   end

   always_ff @(posedge i_CLK) begin
      if (!i_RST_N) begin
         state_q <= IDLE;
         o_VALID <= 1'b0;
         o_OUT   <= '0;
         o_ZERO  <= 1'b0;
         o_NEG   <= 1'b0;
         o_CARRY <= 1'b0;
         o_OVF   <= 1'b0;
      end else begin
         state_q <= state_d;
         o_VALID <= load;
         if (load) begin
            o_OUT   <= res_d;
            o_ZERO  <= (res_d == '0);
            o_NEG   <= res_d[WIDTH-1];
            o_CARRY <= carry_d;
            o_OVF   <= ovf_d;
         end
      end
   end

endmodule

// File: tb/tb_ula_seq.sv
// Directed self-checking bench for ula_seq at WIDTH=8.
module tb_ula_seq;

   logic       clk;
   logic       rst_n;
   logic       valid_in;
   logic       ready;
   logic [3:0] sel;
   logic [7:0] a;
   logic [7:0] b;
   logic       valid_out;
   logic [7:0] out;
   logic       zero;
   logic       neg;
   logic       carry;
   logic       ovf;
   logic [3:0] flags;

   int checks;
   int failures;

   assign flags = {zero, neg, carry, ovf};

   ula_seq #(
      .WIDTH (8)
   ) dut (
      .i_CLK   (clk),
      .i_RST_N (rst_n),
      .i_VALID (valid_in),
      .o_READY (ready),
      .i_SEL   (sel),
      .i_A     (a),
      .i_B     (b),
      .o_VALID (valid_out),
      .o_OUT   (out),
      .o_ZERO  (zero),
      .o_NEG   (neg),
      .o_CARRY (carry),
      .o_OVF   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-cycle vectors {sel, a, b} -> {out, flags(zero,neg,carry,ovf)}
   localparam logic [3:0] TS [8] = '{4'b0000, 4'b0110, 4'b0100, 4'b0101,
                                     4'b1000, 4'b1111, 4'b0011, 4'b0111};
   localparam logic [7:0] TA [8] = '{8'h13, 8'hFF, 8'h0F, 8'h0F, 8'h81, 8'h00, 8'hFF, 8'h80};
   localparam logic [7:0] TB [8] = '{8'h42, 8'h00, 8'hF0, 8'hF0, 8'h00, 8'h80, 8'h01, 8'h01};
   localparam logic [7:0] TO [8] = '{8'h42, 8'h00, 8'hFF, 8'h00, 8'h40, 8'h80, 8'h00, 8'h7F};
   localparam logic [3:0] TF [8] = '{4'b0000, 4'b1000, 4'b0100, 4'b1000,
                                     4'b0010, 4'b0100, 4'b1010, 4'b0001};

   localparam logic [7:0] MA [2] = '{8'h0F, 8'h10};
   localparam logic [7:0] MB [2] = '{8'h11, 8'h10};
   localparam logic [7:0] MO [2] = '{8'hFF, 8'h00};
   localparam logic [3:0] MF [2] = '{4'b0100, 4'b1011};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      valid_in = 1'b1;
      sel = 4'b0011;
      a = 8'h01;
      b = 8'h01;
      step();
      step();
      checks++;
      if (ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_ready got=%b exp=0", ready);
      end
      checks++;
      if ({valid_out, out, flags} !== 13'h0) begin
         failures++;
         $display("FAIL reset_outputs got valid=%b out=%h flags=%b exp all 0",
                  valid_out, out, flags);
      end
      valid_in = 1'b0;
      rst_n = 1'b1;
      #1;
      checks++;
      if (ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_release_ready got=%b exp=1", ready);
      end
      step();
   endtask

   task automatic test_add();
      valid_in = 1'b1;
      sel = 4'b0011;
      a = 8'h7F;
      b = 8'h01;
      step();
      valid_in = 1'b0;
      a = 8'h00;
      b = 8'h00;
      checks++;
      if ({valid_out, out, flags} !== {1'b1, 8'h80, 4'b0101}) begin
         failures++;
         $display("FAIL add_ovf got valid=%b out=%h flags=%b exp valid=1 out=80 flags=0101",
                  valid_out, out, flags);
      end
      step();
      checks++;
      if ({valid_out, out, flags} !== {1'b0, 8'h80, 4'b0101}) begin
         failures++;
         $display("FAIL add_hold got valid=%b out=%h flags=%b exp valid=0 out=80 flags=0101",
                  valid_out, out, flags);
      end
   endtask

   task automatic test_sub();
      valid_in = 1'b1;
      sel = 4'b0111;
      a = 8'h03;
      b = 8'h05;
      step();
      checks++;
      if ({valid_out, out, flags} !== {1'b1, 8'hFE, 4'b0110}) begin
         failures++;
         $display("FAIL sub_borrow got valid=%b out=%h flags=%b exp valid=1 out=fe flags=0110",
                  valid_out, out, flags);
      end
      a = 8'h05;
      step();
      valid_in = 1'b0;
      checks++;
      if ({valid_out, out, flags} !== {1'b1, 8'h00, 4'b1000}) begin
         failures++;
         $display("FAIL sub_zero got valid=%b out=%h flags=%b exp valid=1 out=00 flags=1000",
                  valid_out, out, flags);
      end
      step();
   endtask

   task automatic test_logic();
      valid_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
         sel = TS[i];
         a = TA[i];
         b = TB[i];
         step();
         checks++;
         if ({valid_out, out, flags} !== {1'b1, TO[i], TF[i]}) begin
            failures++;
            $display("FAIL logic_%0d sel=%b got valid=%b out=%h flags=%b exp valid=1 out=%h flags=%b",
                     i, TS[i], valid_out, out, flags, TO[i], TF[i]);
         end
      end
      valid_in = 1'b0;
      step();
   endtask

   task automatic test_mul();
      for (int v = 0; v < 2; v++) begin
         valid_in = 1'b1;
         sel = 4'b1010;
         a = MA[v];
         b = MB[v];
         step();
         valid_in = 1'b0;
         a = 8'h00;
         b = 8'h00;
         for (int k = 0; k < 8; k++) begin
            checks++;
            if ({ready, valid_out} !== 2'b00) begin
               failures++;
               $display("FAIL mul%0d_busy_%0d got ready=%b valid=%b exp ready=0 valid=0",
                        v, k, ready, valid_out);
            end
            step();
         end
         checks++;
         if ({ready, valid_out, out, flags} !== {1'b1, 1'b1, MO[v], MF[v]}) begin
            failures++;
            $display("FAIL mul%0d_done got ready=%b valid=%b out=%h flags=%b exp 1 1 %h %b",
                     v, ready, valid_out, out, flags, MO[v], MF[v]);
         end
      end
      step();
      checks++;
      if (valid_out !== 1'b0) begin
         failures++;
         $display("FAIL mul_single_pulse got valid=%b exp=0", valid_out);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      valid_in = 1'b1;
      sel = 4'b1010;
      a = 8'h02;
      b = 8'h03;
      step();
      sel = 4'b0011;
      a = 8'h01;
      b = 8'h01;
      n = 0;
      while (valid_out !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      checks++;
      if (n !== 8 || out !== 8'h06 || ready !== 1'b1) begin
         failures++;
         $display("FAIL held_mul_done got cycles=%0d out=%h ready=%b exp cycles=8 out=06 ready=1",
                  n, out, ready);
      end
      step();
      valid_in = 1'b0;
      checks++;
      if ({valid_out, out, flags} !== {1'b1, 8'h02, 4'b0000}) begin
         failures++;
         $display("FAIL held_add got valid=%b out=%h flags=%b exp valid=1 out=02 flags=0000",
                  valid_out, out, flags);
      end
      step();
   endtask

   task automatic test_reset_mid_mul();
      int pulses;
      valid_in = 1'b1;
      sel = 4'b1010;
      a = 8'hFF;
      b = 8'hFF;
      step();
      valid_in = 1'b0;
      step();
      step();
      step();
      rst_n = 1'b0;
      step();
      checks++;
      if ({ready, valid_out, out, flags} !== 14'h0) begin
         failures++;
         $display("FAIL rst_mid_mul got ready=%b valid=%b out=%h flags=%b exp all 0",
                  ready, valid_out, out, flags);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (ready !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_mul_ready got=%b exp=1", ready);
      end
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (valid_out === 1'b1) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         failures++;
         $display("FAIL rst_mid_mul_no_valid got pulses=%0d exp=0", pulses);
      end
      valid_in = 1'b1;
      sel = 4'b1001;
      a = 8'h81;
      b = 8'h00;
      step();
      valid_in = 1'b0;
      checks++;
      if ({valid_out, out, flags} !== {1'b1, 8'h02, 4'b0010}) begin
         failures++;
         $display("FAIL shl_after_rst got valid=%b out=%h flags=%b exp valid=1 out=02 flags=0010",
                  valid_out, out, flags);
      end
      step();
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      valid_in = 1'b0;
      sel = 4'b0000;
      a = 8'h00;
      b = 8'h00;
      test_reset();
      test_add();
      test_sub();
      test_mul();
      test_back_to_back();
      test_reset_mid_mul();
      test_logic();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/ula_seq.md
# ula_seq

Parametrised, sequential successor to the Neander arithmetic-logic unit. It keeps the Neander opcode map for ADD/OR/AND/NOT/pass-through and adds SUB, SHR, SHL and an iterative shift-add MUL. Requests are accepted over a valid/ready handshake, and results and flags are registered. It sits between the instruction decoder/control FSM and the accumulator, which loads o_OUT when o_VALID is high.

## Interface
- WIDTH, 8: operand/result width, ≥ 2.
- i_CLK  in  1  clock; all state changes on the rising edge.
- i_RST_N  in  1  reset; synchronous, active-low.
- i_VALID  in  1  request valid.
- o_READY  out  1  unit can accept a request.
- i_SEL  in  4  opcode, sampled on accept.
- i_A  in  WIDTH  operand A (accumulator), sampled on accept.
- i_B  in  WIDTH  operand B (memory), sampled on accept.
- o_VALID  out  1  one-cycle pulse: o_OUT/flags just updated.
- o_OUT  out  WIDTH  registered result.
- o_ZERO, o_NEG, o_CARRY, o_OVF  out  1 each  registered flags.

## Operation
- Accept = i_VALID & o_READY at a rising edge. With i_VALID low or o_READY low, inputs are ignored.
- Opcodes and results:
  - 0011 ADD: A+B.
  - 0100 OR: A|B.
  - 0101 AND: A&B.
  - 0110 NOT: ~A.
  - 0111 SUB: A−B.
  - 1000 SHR: A>>1, zero fill.
  - 1001 SHL: A<<1.
  - 1010 MUL: low WIDTH bits of the unsigned A·B.
  - All other opcodes: pass B (covers LDA and NOP).
- Result arithmetic is modulo 2^WIDTH.
- Every completion sets ZERO = (OUT==0) and NEG = OUT[WIDTH-1].
- CARRY per opcode:
  - ADD: carry-out.
  - SUB: borrow (A<B unsigned).
  - SHR: A[0].
  - SHL: A[WIDTH-1].
  - MUL: upper WIDTH product bits nonzero.
  - All others: 0.
- OVF per opcode:
  - ADD/SUB: two's-complement overflow.
  - MUL: equals CARRY.
  - All others: 0.
- FSM states:
  - IDLE: o_READY=1.
    - Accept of a non-MUL opcode: stay IDLE; o_OUT/flags load and o_VALID=1 on the same edge.
    - Accept of MUL: go to BUSY; latch operands; clear accumulator; count=0.
  - BUSY: o_READY=0.
    - Each edge: if multiplier bit[count] is set, add multiplicand<<count into a 2·WIDTH accumulator; count++.
    - On the edge where count reaches WIDTH−1 (last iteration): load o_OUT/flags from the final product, pulse o_VALID, return to IDLE.
- o_OUT and flags hold their values between completions. No other event alters them.
- There is no output back-pressure. The consumer must capture o_OUT while o_VALID is high, or rely on the held value.

## Timing
- Reset (i_RST_N low at an edge) sets:
  - state=IDLE;
  - o_OUT=0; all flags 0; o_VALID=0;
  - count and accumulator cleared.
- o_READY=0 while i_RST_N is low.
- Reset dominates any concurrent accept.
- Reset mid-MUL: the operation is discarded and no o_VALID is produced. o_READY=1 in the first cycle after release.
- Non-MUL latency: accept at edge t → o_OUT/flags valid and o_VALID=1 in the cycle following t. Throughput is 1 per cycle.
- MUL latency: accept at edge t → completion at edge t+WIDTH. o_VALID is high in the cycle after t+WIDTH. o_READY is low during cycles t..t+WIDTH−1, counted as the cycles following those edges.
- o_READY returns to 1 in the same cycle o_VALID pulses, so back-to-back accept is legal.
- i_VALID while BUSY is ignored. The requester holds the request until it sees o_READY.
- o_VALID is never high for two consecutive cycles from one request.

## Structure
- Package ula_pkg holds:
  - 4-bit opcode localparams (OP_ADD, OP_OR, OP_AND, OP_NOT, OP_SUB, OP_SHR, OP_SHL, OP_MUL);
  - the FSM state typedef {IDLE, BUSY}.
- Sub-module ula_mul_iter:
  - contents: operand latches, iteration counter of width $clog2(WIDTH), 2·WIDTH accumulator;
  - inputs: start strobe;
  - outputs: done strobe and product.
- The top module holds the combinational single-cycle datapath, the flag logic, the FSM and the output registers.

## Test plan
All scenarios use WIDTH=8.
- ADD A=0x7F, B=0x01 → next cycle: OUT=0x80, NEG=1, OVF=1, CARRY=0, ZERO=0, o_VALID one cycle.
- SUB A=0x03, B=0x05 → OUT=0xFE, CARRY=1, NEG=1, OVF=0. Then SUB A=0x05, B=0x05 → OUT=0x00, ZERO=1, CARRY=0.
- MUL A=0x0F, B=0x11 → o_READY low 8 cycles; OUT=0xFF, CARRY=0, OVF=0 with o_VALID 8 cycles after accept. Then MUL A=0x10, B=0x10 → OUT=0x00, ZERO=1, CARRY=1, OVF=1.
- ADD 0x01+0x01 with i_VALID held during a MUL busy period → ignored until o_READY=1; accepted on the o_VALID cycle; OUT=0x02 the following cycle.
- Reset asserted 4 cycles into a MUL → all outputs 0 and no o_VALID. After release, o_READY=1, and SHL A=0x81 → OUT=0x02, CARRY=1.
- Opcode 0000 with B=0x42 → OUT=0x42, flags ZERO=0, NEG=0, CARRY=0, OVF=0. NOT A=0xFF → OUT=0x00, ZERO=1.
